// File: rtl/rib_arb2.sv
// Two-master arbiter in front of a single-outstanding slave port (TCM controller).
// Round-robin or fixed priority; one-entry hold buffer when the owner cannot take a response.
module rib_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_m0_addr,
  input  logic        i_m0_wrcs,
  input  logic [3:0]  i_m0_mask,
  input  logic [31:0] i_m0_wdata,
  input  logic        i_m0_req,
  output logic        o_m0_gnt,
  output logic        o_m0_rsp,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m0_rdy,
  input  logic [31:0] i_m1_addr,
  input  logic        i_m1_wrcs,
  input  logic [3:0]  i_m1_mask,
  input  logic [31:0] i_m1_wdata,
  input  logic        i_m1_req,
  output logic        o_m1_gnt,
  output logic        o_m1_rsp,
  output logic [31:0] o_m1_rdata,
  input  logic        i_m1_rdy,
  output logic [31:0] o_s_addr,
  output logic        o_s_wrcs,
  output logic [3:0]  o_s_mask,
  output logic [31:0] o_s_wdata,
  output logic        o_s_req,
  input  logic        i_s_gnt,
  input  logic        i_s_rsp,
  input  logic [31:0] i_s_rdata,
  output logic        o_s_rdy
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic        r_last;
  logic        r_locked;
  logic        r_lock_sel;
  logic [31:0] r_hold_data;

  logic        w_owner_rdy;
  logic        w_rsp_live;
  logic        w_issue_ok;
  logic        w_sel;
  logic        w_grant;
  logic        w_rsp_vld;
  logic [31:0] w_rsp_data;

  assign w_owner_rdy = r_owner ? i_m1_rdy : i_m0_rdy;
  assign w_rsp_live  = (r_state == BUSY) && i_s_rsp;
  assign w_issue_ok  = i_rstn && ((r_state == IDLE) || (w_rsp_live && w_owner_rdy));

  // A stalled request keeps its master until the slave grants it.
  always_comb begin
    w_sel = 1'b0;
    if (r_locked && (r_lock_sel ? i_m1_req : i_m0_req))
      w_sel = r_lock_sel;
    else if (i_m0_req && i_m1_req)
      w_sel = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
    else
      w_sel = i_m1_req;
  end

  assign o_s_req   = w_issue_ok && (i_m0_req || i_m1_req);
  assign w_grant   = o_s_req && i_s_gnt;
  assign o_m0_gnt  = w_grant && !w_sel;
  assign o_m1_gnt  = w_grant && w_sel;
  assign o_s_addr  = w_sel ? i_m1_addr  : i_m0_addr;
  assign o_s_wrcs  = w_sel ? i_m1_wrcs  : i_m0_wrcs;
  assign o_s_mask  = w_sel ? i_m1_mask  : i_m0_mask;
  assign o_s_wdata = w_sel ? i_m1_wdata : i_m0_wdata;
  assign o_s_rdy   = !i_rstn || (r_state != HOLD);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_locked    <= 1'b0;
      r_lock_sel  <= 1'b0;
      r_hold_data <= '0;
    end else begin
      r_locked   <= o_s_req && !i_s_gnt;
      r_lock_sel <= w_sel;
      if (w_grant) begin
        r_owner <= w_sel;
        r_last  <= w_sel;
      end
      if (w_rsp_live && !w_owner_rdy) r_hold_data <= i_s_rdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_grant) w_state_nxt = BUSY;
      BUSY: begin
        if (i_s_rsp) begin
          if (!w_owner_rdy)  w_state_nxt = HOLD;
          else if (w_grant)  w_state_nxt = BUSY;
          else               w_state_nxt = IDLE;
        end
      end
      HOLD: if (w_owner_rdy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Live slave data passes straight through; held data replays until the owner is ready.
  assign w_rsp_vld  = i_rstn && (w_rsp_live || (r_state == HOLD));
  assign w_rsp_data = (r_state == HOLD) ? r_hold_data : i_s_rdata;

  always_comb begin
    o_m0_rsp   = 1'b0;
    o_m1_rsp   = 1'b0;
    o_m0_rdata = '0;
    o_m1_rdata = '0;
    if (w_rsp_vld) begin
      if (r_owner) begin
        o_m1_rsp   = 1'b1;
        o_m1_rdata = w_rsp_data;
      end else begin
        o_m0_rsp   = 1'b1;
        o_m0_rdata = w_rsp_data;
      end
    end
  end
endmodule

// File: tb/tb_rib_arb2.sv
// Bench for rib_arb2: directed cycle table, fixed-priority sequence, and a
// randomized run against a transaction-level reference model.
module tb_rib_arb2;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
  logic        m0_wrcs, m1_wrcs, m0_req, m1_req, m0_rdy, m1_rdy, s_gnt, s_rsp;
  logic [3:0]  m0_mask, m1_mask;

  logic        m0_gnt, m1_gnt, m0_rsp, m1_rsp, s_wrcs, s_req, s_rdy;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_mask;

  logic        f_m0_gnt, f_m1_gnt, f_m0_rsp, f_m1_rsp, f_s_wrcs, f_s_req, f_s_rdy;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata;
  logic [3:0]  f_s_mask;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  rib_arb2 #(.FIXED_PRIO(0)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_m0_addr(m0_addr), .i_m0_wrcs(m0_wrcs), .i_m0_mask(m0_mask), .i_m0_wdata(m0_wdata),
    .i_m0_req(m0_req), .o_m0_gnt(m0_gnt), .o_m0_rsp(m0_rsp), .o_m0_rdata(m0_rdata), .i_m0_rdy(m0_rdy),
    .i_m1_addr(m1_addr), .i_m1_wrcs(m1_wrcs), .i_m1_mask(m1_mask), .i_m1_wdata(m1_wdata),
    .i_m1_req(m1_req), .o_m1_gnt(m1_gnt), .o_m1_rsp(m1_rsp), .o_m1_rdata(m1_rdata), .i_m1_rdy(m1_rdy),
    .o_s_addr(s_addr), .o_s_wrcs(s_wrcs), .o_s_mask(s_mask), .o_s_wdata(s_wdata),
    .o_s_req(s_req), .i_s_gnt(s_gnt), .i_s_rsp(s_rsp), .i_s_rdata(s_rdata), .o_s_rdy(s_rdy)
  );

  rib_arb2 #(.FIXED_PRIO(1)) dut_fp (
    .i_clk(clk), .i_rstn(rstn),
    .i_m0_addr(m0_addr), .i_m0_wrcs(m0_wrcs), .i_m0_mask(m0_mask), .i_m0_wdata(m0_wdata),
    .i_m0_req(m0_req), .o_m0_gnt(f_m0_gnt), .o_m0_rsp(f_m0_rsp), .o_m0_rdata(f_m0_rdata), .i_m0_rdy(m0_rdy),
    .i_m1_addr(m1_addr), .i_m1_wrcs(m1_wrcs), .i_m1_mask(m1_mask), .i_m1_wdata(m1_wdata),
    .i_m1_req(m1_req), .o_m1_gnt(f_m1_gnt), .o_m1_rsp(f_m1_rsp), .o_m1_rdata(f_m1_rdata), .i_m1_rdy(m1_rdy),
    .o_s_addr(f_s_addr), .o_s_wrcs(f_s_wrcs), .o_s_mask(f_s_mask), .o_s_wdata(f_s_wdata),
    .o_s_req(f_s_req), .i_s_gnt(s_gnt), .i_s_rsp(s_rsp), .i_s_rdata(s_rdata), .o_s_rdy(f_s_rdy)
  );

  typedef struct {
    logic rstn, r0, r1, sg, sr;
    logic [31:0] sd;
    logic y0, y1;
    logic g0, g1, p0, p1, sq, sy;
    logic [31:0] d0, d1;
    logic es;
  } vec_t;

  function automatic vec_t v(input logic rs, r0, r1, sg, sr, input logic [31:0] sd,
                             input logic y0, y1, g0, g1, p0, p1, sq, sy,
                             input logic [31:0] d0, d1, input logic es);
    vec_t t;
    t.rstn = rs; t.r0 = r0; t.r1 = r1; t.sg = sg; t.sr = sr; t.sd = sd; t.y0 = y0; t.y1 = y1;
    t.g0 = g0; t.g1 = g1; t.p0 = p0; t.p1 = p1; t.sq = sq; t.sy = sy; t.d0 = d0; t.d1 = d1; t.es = es;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk_all(input string t, input logic eg0, eg1, ep0, ep1, esq, esy,
                         input logic [31:0] ed0, ed1, input logic es);
    chk({t, " m0_gnt"}, {31'd0, m0_gnt}, {31'd0, eg0});
    chk({t, " m1_gnt"}, {31'd0, m1_gnt}, {31'd0, eg1});
    chk({t, " m0_rsp"}, {31'd0, m0_rsp}, {31'd0, ep0});
    chk({t, " m1_rsp"}, {31'd0, m1_rsp}, {31'd0, ep1});
    chk({t, " s_req"},  {31'd0, s_req},  {31'd0, esq});
    chk({t, " s_rdy"},  {31'd0, s_rdy},  {31'd0, esy});
    chk({t, " m0_rdata"}, m0_rdata, ed0);
    chk({t, " m1_rdata"}, m1_rdata, ed1);
    if (esq) begin
      chk({t, " s_addr"},  s_addr,  es ? m1_addr : m0_addr);
      chk({t, " s_wrcs"},  {31'd0, s_wrcs}, {31'd0, es ? m1_wrcs : m0_wrcs});
      chk({t, " s_mask"},  {28'd0, s_mask}, {28'd0, es ? m1_mask : m0_mask});
      chk({t, " s_wdata"}, s_wdata, es ? m1_wdata : m0_wdata);
    end
  endtask

  task automatic drive(input logic rs, r0, r1, sg, sr, input logic [31:0] sd, input logic y0, y1);
    rstn = rs; m0_req = r0; m1_req = r1; s_gnt = sg; s_rsp = sr; s_rdata = sd;
    m0_rdy = y0; m1_rdy = y1;
  endtask

  // Reference model state: transaction owner (-1 none), held response, arbitration history.
  int          m_owner, m_last, m_locked;
  bit          m_held, s_pend;
  logic [31:0] m_hdata, s_pdata;

  initial begin
    vec_t tbl[26];
    m0_addr = 32'h100; m0_wrcs = 1'b0; m0_mask = 4'hF;    m0_wdata = 32'hA0A0A0A0;
    m1_addr = 32'h8;   m1_wrcs = 1'b1; m1_mask = 4'b0011; m1_wdata = 32'hB1B1B1B1;
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    @(posedge clk); #1;

    tbl[0]  = v(0,1,1,1,1,32'h55,1,1,       0,0,0,0,0,1, 0,0,0);
    tbl[1]  = v(0,1,1,1,1,32'h55,1,1,       0,0,0,0,0,1, 0,0,0);
    tbl[2]  = v(1,1,1,1,0,0,1,1,            1,0,0,0,1,1, 0,0,0);
    tbl[3]  = v(1,1,1,1,1,32'h1111,1,1,     0,1,1,0,1,1, 32'h1111,0,1);
    tbl[4]  = v(1,1,1,1,1,32'h2222,1,1,     1,0,0,1,1,1, 0,32'h2222,0);
    tbl[5]  = v(1,1,1,1,1,32'h3333,1,1,     0,1,1,0,1,1, 32'h3333,0,1);
    tbl[6]  = v(1,0,0,1,1,32'h4444,1,1,     0,0,0,1,0,1, 0,32'h4444,0);
    tbl[7]  = v(1,0,0,1,1,32'h5555,1,1,     0,0,0,0,0,1, 0,0,0);
    tbl[8]  = v(1,0,1,1,0,0,1,1,            0,1,0,0,1,1, 0,0,1);
    tbl[9]  = v(1,0,0,1,1,32'h6666,1,1,     0,0,0,1,0,1, 0,32'h6666,0);
    tbl[10] = v(1,1,0,1,0,0,1,1,            1,0,0,0,1,1, 0,0,0);
    tbl[11] = v(1,0,0,1,1,32'hDEADBEEF,0,1, 0,0,1,0,0,1, 32'hDEADBEEF,0,0);
    tbl[12] = v(1,1,1,1,1,32'h7777,0,1,     0,0,1,0,0,0, 32'hDEADBEEF,0,0);
    tbl[13] = v(1,1,1,1,1,32'h7777,0,1,     0,0,1,0,0,0, 32'hDEADBEEF,0,0);
    tbl[14] = v(1,1,1,1,1,32'h7777,1,1,     0,0,1,0,0,0, 32'hDEADBEEF,0,0);
    tbl[15] = v(1,1,1,1,0,0,1,1,            0,1,0,0,1,1, 0,0,1);
    tbl[16] = v(0,1,1,1,1,32'h9999,1,1,     0,0,0,0,0,1, 0,0,0);
    tbl[17] = v(1,0,0,1,1,32'hAAAA,1,1,     0,0,0,0,0,1, 0,0,0);
    tbl[18] = v(1,0,1,1,0,0,1,1,            0,1,0,0,1,1, 0,0,1);
    tbl[19] = v(1,0,0,1,1,32'hBBBB,1,1,     0,0,0,1,0,1, 0,32'hBBBB,0);
    tbl[20] = v(1,0,1,0,0,0,1,1,            0,0,0,0,1,1, 0,0,1);
    tbl[21] = v(1,0,1,0,0,0,1,1,            0,0,0,0,1,1, 0,0,1);
    tbl[22] = v(1,1,1,0,0,0,1,1,            0,0,0,0,1,1, 0,0,1);
    tbl[23] = v(1,1,1,1,0,0,1,1,            0,1,0,0,1,1, 0,0,1);
    tbl[24] = v(1,1,0,1,1,32'hCCCC,1,1,     1,0,0,1,1,1, 0,32'hCCCC,0);
    tbl[25] = v(1,0,0,1,1,32'hDDDD,1,1,     0,0,1,0,0,1, 32'hDDDD,0,0);

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].rstn, tbl[i].r0, tbl[i].r1, tbl[i].sg, tbl[i].sr, tbl[i].sd, tbl[i].y0, tbl[i].y1);
      @(negedge clk);
      chk_all($sformatf("row%0d", i), tbl[i].g0, tbl[i].g1, tbl[i].p0, tbl[i].p1,
              tbl[i].sq, tbl[i].sy, tbl[i].d0, tbl[i].d1, tbl[i].es);
      @(posedge clk); #1;
    end

    // Fixed priority: m0 wins every cycle while both request.
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 1, 1, k > 0, 32'h100 + k, 1, 1);
      @(negedge clk);
      chk($sformatf("fp%0d m0_gnt", k), {31'd0, f_m0_gnt}, 32'd1);
      chk($sformatf("fp%0d m1_gnt", k), {31'd0, f_m1_gnt}, 32'd0);
      chk($sformatf("fp%0d m0_rdata", k), f_m0_rdata, (k > 0) ? 32'h100 + k : 32'd0);
      @(posedge clk); #1;
    end

    // Randomized run against the reference model.
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    @(posedge clk); #1;
    m_owner = -1; m_held = 0; m_hdata = '0; m_last = 1; m_locked = -1; s_pend = 0; s_pdata = '0;
    for (int c = 0; c < 1500; c++) begin
      logic eg0, eg1, ep0, ep1, esq, esy, busy, ordy, allowed, sel;
      logic [31:0] ed0, ed1, rd;
      m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
      m0_wrcs = 1'($urandom); m1_wrcs = 1'($urandom);
      m0_mask = 4'($urandom); m1_mask = 4'($urandom);
      rstn   = ($urandom_range(0, 99) != 0);
      m0_req = ($urandom_range(0, 2) != 0);
      m1_req = ($urandom_range(0, 2) != 0);
      s_gnt  = ($urandom_range(0, 3) != 0);
      m0_rdy = ($urandom_range(0, 3) != 0);
      m1_rdy = ($urandom_range(0, 3) != 0);
      s_rsp  = s_pend ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      rd     = $urandom;
      s_rdata = s_pend ? s_pdata : rd;

      eg0 = 0; eg1 = 0; ep0 = 0; ep1 = 0; esq = 0; esy = 1; ed0 = 0; ed1 = 0; sel = 0;
      busy = (m_owner >= 0) && !m_held;
      ordy = (m_owner == 1) ? m1_rdy : m0_rdy;
      if (rstn) begin
        allowed = (m_owner < 0) || (busy && s_rsp && ordy);
        if (m_locked >= 0 && ((m_locked == 1) ? m1_req : m0_req)) sel = (m_locked == 1);
        else if (m0_req && m1_req) sel = (m_last == 0);
        else sel = m1_req;
        esq = allowed && (m0_req || m1_req);
        eg0 = esq && s_gnt && !sel;
        eg1 = esq && s_gnt && sel;
        esy = !m_held;
        if (m_held || (busy && s_rsp)) begin
          if (m_owner == 1) begin ep1 = 1; ed1 = m_held ? m_hdata : s_rdata; end
          else begin ep0 = 1; ed0 = m_held ? m_hdata : s_rdata; end
        end
      end

      @(negedge clk);
      chk_all($sformatf("rnd%0d", c), eg0, eg1, ep0, ep1, esq, esy, ed0, ed1, sel);

      if (!rstn) begin
        m_owner = -1; m_held = 0; m_last = 1; m_locked = -1; s_pend = 0;
      end else begin
        m_locked = (esq && !s_gnt) ? int'(sel) : -1;
        if (m_held) begin
          if (ordy) begin m_owner = -1; m_held = 0; end
        end else if (busy && s_rsp) begin
          s_pend = 0;
          if (!ordy) begin m_held = 1; m_hdata = s_rdata; end
          else m_owner = -1;
        end
        if (eg0 || eg1) begin
          m_owner = int'(sel); m_last = int'(sel); s_pend = 1; s_pdata = $urandom;
        end
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/rib_arb2.md
RIB_ARB2 -- requirements
Module: rib_arb2

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = master 0 always wins.
REQ-002 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rstn, input, 1: synchronous active-low reset, sampled on rising i_clk.
REQ-004 SHALL have, for N=0,1, port i_mN_addr, input, 32: master N address.
REQ-005 SHALL have, for N=0,1, port i_mN_wrcs, input, 1: master N write select (1 = write).
REQ-006 SHALL have, for N=0,1, port i_mN_mask, input, 4: master N byte mask.
REQ-007 SHALL have, for N=0,1, port i_mN_wdata, input, 32: master N write data.
REQ-008 SHALL have, for N=0,1, port i_mN_req, input, 1: master N request.
REQ-009 SHALL have, for N=0,1, port o_mN_gnt, output, 1: master N request accepted this cycle.
REQ-010 SHALL have, for N=0,1, port o_mN_rsp, output, 1: response valid to master N.
REQ-011 SHALL have, for N=0,1, port o_mN_rdata, output, 32: response data to master N.
REQ-012 SHALL have, for N=0,1, port i_mN_rdy, input, 1: master N can take a response.
REQ-013 SHALL have ports o_s_addr (32), o_s_wrcs (1), o_s_mask (4), o_s_wdata (32), all outputs: slave command.
REQ-014 SHALL have port o_s_req, output, 1: request to the slave (TCM controller).
REQ-015 SHALL have port i_s_gnt, input, 1: slave accepted the request.
REQ-016 SHALL have port i_s_rsp, input, 1: slave response valid.
REQ-017 SHALL have port i_s_rdata, input, 32: slave response data.
REQ-018 SHALL have port o_s_rdy, output, 1: arbiter can take a slave response.

Function
REQ-019 SHALL implement states IDLE (nothing outstanding), BUSY (one slave transaction outstanding, owner recorded), HOLD (response captured, awaiting owner rdy).
REQ-020 SHALL compute issue-allowed = IDLE, or BUSY with i_s_rsp=1 and the owner's i_mN_rdy=1; in HOLD, and in BUSY otherwise, issue-allowed SHALL be 0.
REQ-021 SHALL drive o_s_req = issue-allowed AND (i_m0_req OR i_m1_req), and SHALL mux the selected master's addr/wrcs/mask/wdata onto o_s_*.
REQ-022 SHALL select, when both masters request and FIXED_PRIO=0, the master not granted most recently; SHALL select m0 when FIXED_PRIO=1; a single requester SHALL always be selected.
REQ-023 SHALL keep the selection locked while o_s_req=1 and i_s_gnt=0 (slave stall), with no re-arbitration until the grant.
REQ-024 SHALL assert o_mN_gnt = o_s_req AND i_s_gnt AND selected==N, combinationally in the same cycle.
REQ-025 SHALL, on grant, record the owner, update the last-granted pointer, and enter or stay in BUSY the next cycle.
REQ-026 SHALL, in BUSY with i_s_rsp=1, assert o_mN_rsp for the owner and pass i_s_rdata to o_mN_rdata combinationally, with zero added latency.
REQ-027 SHALL, in BUSY with i_s_rsp=1 and owner rdy=0, capture i_s_rdata into a hold register and go to HOLD.
REQ-028 SHALL, in HOLD, assert the owner's o_mN_rsp with the held data until its rdy=1, then go to IDLE; no slave request SHALL issue in that cycle.
REQ-029 SHALL, in BUSY with i_s_rsp=1 and rdy=1 but no new grant, go to IDLE.
REQ-030 SHALL drive o_s_rdy = 1 except in HOLD.
REQ-031 SHALL ignore i_s_rsp in IDLE and HOLD and SHALL NOT forward it to either master.
REQ-032 SHALL hold the non-owner's o_mN_rsp at 0, and SHALL drive o_mN_rdata to 0 whenever o_mN_rsp=0.
REQ-033 SHALL sustain one transaction per cycle with a 1-cycle-response slave that always grants and masters that are always ready.

Reset
REQ-034 SHALL, while i_rstn=0 at a clock edge, set state IDLE, clear the owner and hold registers, and set the last-granted pointer to m1 so that m0 wins the first tie.
REQ-035 SHALL, during reset, drive all o_mN_gnt, o_mN_rsp and o_s_req to 0 and o_s_rdy to 1.
REQ-036 SHALL, on reset mid-transaction, discard the outstanding or held response; a slave response arriving after reset SHALL be ignored.

Verification
REQ-037 Scenario: both masters request continuously for 4 cycles, FIXED_PRIO=0, slave grants and responds 1 cycle later -> grants m0,m1,m0,m1; each rsp goes to the correct master with the matching data.
REQ-038 Scenario: FIXED_PRIO=1, both masters request continuously -> m0 is granted every cycle and m1 is never granted.
REQ-039 Scenario: m0 reads 0x100, m0 rdy=0 for 3 cycles, slave returns 0xDEADBEEF -> HOLD entered; o_m0_rsp=1 with 0xDEADBEEF for 3 cycles; o_s_req=0 throughout; IDLE after rdy.
REQ-040 Scenario: i_s_gnt=0 for 2 cycles with m1 selected, then m0 also requests -> m1 stays selected and is granted first.
REQ-041 Scenario: m1 writes mask 4'b0011 to 0x8 -> o_s_addr=0x8, o_s_mask=0011, o_s_wrcs=1 in the grant cycle; o_m1_rsp one cycle later.
REQ-042 Scenario: i_rstn=0 in the cycle after a grant -> no o_mN_rsp is raised; the next request after reset is accepted from IDLE.
